// File: rtl/datapath_pkg.sv
// Shared encodings for the two-stage datapath: function-select codes,
// result-source codes and bit positions inside the {V,C,N,Z} flag vector.
package datapath_pkg;

    localparam logic [2:0] FS_ADD = 3'd0;
    localparam logic [2:0] FS_SUB = 3'd1;
    localparam logic [2:0] FS_AND = 3'd2;
    localparam logic [2:0] FS_OR  = 3'd3;
    localparam logic [2:0] FS_XOR = 3'd4;
    localparam logic [2:0] FS_NOT = 3'd5;
    localparam logic [2:0] FS_SHL = 3'd6;
    localparam logic [2:0] FS_SHR = 3'd7;

    localparam logic [1:0] RS_F   = 2'd0;
    localparam logic [1:0] RS_PC  = 2'd1;
    localparam logic [1:0] RS_MEM = 2'd2;
    localparam logic [1:0] RS_IMM = 2'd3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/reg_file.sv
// Register file: 2**ADDR_W words, synchronous write and reset,
// three asynchronous read ports (A, B, D).
module reg_file #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [WIDTH-1:0]  i_wd,
    input  logic [ADDR_W-1:0] i_ra_a,
    input  logic [ADDR_W-1:0] i_ra_b,
    input  logic [ADDR_W-1:0] i_ra_d,
    output logic [WIDTH-1:0]  o_rd_a,
    output logic [WIDTH-1:0]  o_rd_b,
    output logic [WIDTH-1:0]  o_rd_d
);

    logic [WIDTH-1:0] r_regs [2**ADDR_W];

    // Storage update: reset clears every word, otherwise one write per cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                r_regs[i] <= {WIDTH{1'b0}};
            end
        end else if (i_we) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd_a = r_regs[i_ra_a];
    assign o_rd_b = r_regs[i_ra_b];
    assign o_rd_d = r_regs[i_ra_d];

endmodule

// File: rtl/cpu_datapath_pipe.sv
// Two-stage CPU datapath (issue / writeback). Define DATAPATH_FWD_EN to bypass
// the writeback result into S, T and Dout; otherwise a hazard stalls issue one cycle.
module cpu_datapath_pipe
    import datapath_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] DA,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic [2:0]        FS,
    input  logic              MB,
    input  logic [1:0]        result_source,
    input  logic              RW,
    input  logic [WIDTH-1:0]  MemIn,
    input  logic [WIDTH-1:0]  PC,
    output logic [WIDTH-1:0]  MemAddr,
    output logic [WIDTH-1:0]  Dout,
    output logic [3:0]        flags,
    output logic              wb_valid
);

    logic              r_wb_valid;
    logic              r_wb_rw;
    logic [ADDR_W-1:0] r_wb_da;
    logic [WIDTH-1:0]  r_wb_result;
    logic [3:0]        r_flags;

    logic [WIDTH-1:0]    w_rd_a, w_rd_b, w_rd_d;
    logic [WIDTH-1:0]    w_s, w_t_reg, w_t, w_dout;
    logic                w_wb_write, w_haz_a, w_haz_b, w_haz_d;
    logic                w_stall, w_issue, w_we;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_alu_f, w_result, w_imm;
    logic                w_alu_c, w_alu_v;
    logic [3:0]          w_new_flags;
    logic [2*ADDR_W-1:0] w_imm_raw;

    // A writeback still in flight is dropped if reset arrives first
    assign w_we = r_wb_valid & r_wb_rw & ~reset;

    reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_reg_file (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (w_we),
        .i_wa    (r_wb_da),
        .i_wd    (r_wb_result),
        .i_ra_a  (AA),
        .i_ra_b  (BA),
        .i_ra_d  (DA),
        .o_rd_a  (w_rd_a),
        .o_rd_b  (w_rd_b),
        .o_rd_d  (w_rd_d)
    );

    assign w_wb_write = r_wb_valid & r_wb_rw;
    assign w_haz_a    = w_wb_write & (r_wb_da == AA);
    assign w_haz_b    = w_wb_write & ~MB & (r_wb_da == BA);
    assign w_haz_d    = w_wb_write & (r_wb_da == DA);

`ifdef DATAPATH_FWD_EN
    assign w_s     = w_haz_a ? r_wb_result : w_rd_a;
    assign w_t_reg = w_haz_b ? r_wb_result : w_rd_b;
    assign w_dout  = w_haz_d ? r_wb_result : w_rd_d;
    assign w_stall = 1'b0;
`else
    // The register file commits at the end of the stall cycle, so one cycle suffices
    assign w_s     = w_rd_a;
    assign w_t_reg = w_rd_b;
    assign w_dout  = w_rd_d;
    assign w_stall = in_valid & (w_haz_a | w_haz_b | w_haz_d);
`endif

    assign w_t      = MB ? {{(WIDTH-ADDR_W){1'b0}}, BA} : w_t_reg;
    assign in_ready = ~reset & ~w_stall;
    assign w_issue  = in_valid & in_ready;
    assign MemAddr  = w_s;
    assign Dout     = w_dout;

    assign w_imm_raw = {AA, BA};
    assign w_imm     = WIDTH'($signed(w_imm_raw));

    // Function unit; SUB computes S + ~T + 1 so the carry out is not-borrow
    always_comb begin
        w_sum   = {(WIDTH+1){1'b0}};
        w_alu_f = {WIDTH{1'b0}};
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (FS)
            FS_ADD: begin
                w_sum   = {1'b0, w_s} + {1'b0, w_t};
                w_alu_f = w_sum[WIDTH-1:0];
                w_alu_c = w_sum[WIDTH];
                w_alu_v = (w_s[WIDTH-1] == w_t[WIDTH-1]) & (w_alu_f[WIDTH-1] != w_s[WIDTH-1]);
            end
            FS_SUB: begin
                w_sum   = {1'b0, w_s} + {1'b0, ~w_t} + {{WIDTH{1'b0}}, 1'b1};
                w_alu_f = w_sum[WIDTH-1:0];
                w_alu_c = w_sum[WIDTH];
                w_alu_v = (w_s[WIDTH-1] != w_t[WIDTH-1]) & (w_alu_f[WIDTH-1] != w_s[WIDTH-1]);
            end
            FS_AND: w_alu_f = w_s & w_t;
            FS_OR:  w_alu_f = w_s | w_t;
            FS_XOR: w_alu_f = w_s ^ w_t;
            FS_NOT: w_alu_f = ~w_s;
            FS_SHL: begin
                w_alu_f = {w_s[WIDTH-2:0], 1'b0};
                w_alu_c = w_s[WIDTH-1];
            end
            FS_SHR: begin
                w_alu_f = {1'b0, w_s[WIDTH-1:1]};
                w_alu_c = w_s[0];
            end
            default: w_alu_f = {WIDTH{1'b0}};
        endcase
    end

    // Result select and flag vector for the issuing instruction
    always_comb begin
        w_new_flags         = 4'b0000;
        w_new_flags[FLAG_Z] = (w_alu_f == {WIDTH{1'b0}});
        w_new_flags[FLAG_N] = w_alu_f[WIDTH-1];
        w_new_flags[FLAG_C] = w_alu_c;
        w_new_flags[FLAG_V] = w_alu_v;
        case (result_source)
            RS_F:    w_result = w_alu_f;
            RS_PC:   w_result = PC;
            RS_MEM:  w_result = MemIn;
            RS_IMM:  w_result = w_imm;
            default: w_result = w_alu_f;
        endcase
    end

    // Writeback stage and flag register; flags move only on FU-result issues
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid  <= 1'b0;
            r_wb_rw     <= 1'b0;
            r_wb_da     <= {ADDR_W{1'b0}};
            r_wb_result <= {WIDTH{1'b0}};
            r_flags     <= 4'b0000;
        end else if (w_issue) begin
            r_wb_valid  <= 1'b1;
            r_wb_rw     <= RW;
            r_wb_da     <= DA;
            r_wb_result <= w_result;
            if (result_source == RS_F) begin
                r_flags <= w_new_flags;
            end
        end else begin
            r_wb_valid <= 1'b0;
        end
    end

    assign wb_valid = r_wb_valid;
    assign flags    = r_flags;

endmodule

// File: tb/tb_cpu_datapath_pipe.sv
// Directed self-checking bench for cpu_datapath_pipe (default 16-bit, 16 registers).
module tb_cpu_datapath_pipe;

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_AND = 3'd2;
    localparam logic [2:0] F_OR  = 3'd3;
    localparam logic [2:0] F_XOR = 3'd4;
    localparam logic [2:0] F_SHL = 3'd6;
    localparam logic [2:0] F_SHR = 3'd7;
    localparam logic [1:0] S_F   = 2'd0;
    localparam logic [1:0] S_PC  = 2'd1;
    localparam logic [1:0] S_MEM = 2'd2;
    localparam logic [1:0] S_IMM = 2'd3;
`ifdef DATAPATH_FWD_EN
    localparam int EXP_B2B_STALLS = 0;
`else
    localparam int EXP_B2B_STALLS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  DA, AA, BA;
    logic [2:0]  FS;
    logic        MB;
    logic [1:0]  result_source;
    logic        RW;
    logic [15:0] MemIn, PC, MemAddr, Dout;
    logic [3:0]  flags;
    logic        wb_valid;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          stalls   = 0;
    logic [15:0] acc_memaddr;

    cpu_datapath_pipe #(.WIDTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .DA(DA), .AA(AA), .BA(BA), .FS(FS), .MB(MB), .result_source(result_source),
        .RW(RW), .MemIn(MemIn), .PC(PC), .MemAddr(MemAddr), .Dout(Dout),
        .flags(flags), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present an instruction, wait (bounded) for acceptance, then drop in_valid
    task automatic issue(input string tag, input logic [3:0] da, input logic [3:0] aa,
                         input logic [3:0] ba, input logic [2:0] fs, input logic mb,
                         input logic [1:0] rs, input logic rw);
        int cyc;
        DA = da; AA = aa; BA = ba; FS = fs; MB = mb; result_source = rs; RW = rw;
        in_valid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 8) begin
            stalls++;
            cyc++;
            @(negedge clk);
        end
        if (!in_ready) check_eq({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
        acc_memaddr = MemAddr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic read_reg(input string tag, input logic [3:0] r, input logic [15:0] exp);
        @(posedge clk);
        #1;
        AA = r; DA = r;
        @(negedge clk);
        check_eq({tag, "_memaddr"}, {16'd0, MemAddr}, {16'd0, exp});
        check_eq({tag, "_dout"}, {16'd0, Dout}, {16'd0, exp});
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0;
        DA = 4'd0; AA = 4'd0; BA = 4'd0; FS = 3'd0; MB = 1'b0;
        result_source = 2'd0; RW = 1'b0; MemIn = 16'd0; PC = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready_low", {31'd0, in_ready}, 32'd0);
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_flags", {28'd0, flags}, 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);
        read_reg("rst_r5", 4'd5, 16'h0000);

        // Sign-extended immediate, flags untouched
        issue("imm", 4'd1, 4'hF, 4'h6, F_ADD, 1'b1, S_IMM, 1'b1);
        check_eq("imm_wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("imm_flags", {28'd0, flags}, 32'd0);
        read_reg("imm_r1", 4'd1, 16'hFFF6);
        @(negedge clk);
        check_eq("idle_wb_valid", {31'd0, wb_valid}, 32'd0);

        // Subtraction both ways
        issue("ld_r1", 4'd1, 4'h0, 4'h5, F_ADD, 1'b1, S_IMM, 1'b1);
        issue("ld_r2", 4'd2, 4'h0, 4'h3, F_ADD, 1'b1, S_IMM, 1'b1);
        issue("sub1", 4'd3, 4'd1, 4'd2, F_SUB, 1'b0, S_F, 1'b1);
        check_eq("sub1_flags", {28'd0, flags}, 32'h4);
        read_reg("sub1_r3", 4'd3, 16'h0002);
        issue("sub2", 4'd3, 4'd2, 4'd1, F_SUB, 1'b0, S_F, 1'b1);
        check_eq("sub2_flags", {28'd0, flags}, 32'h2);
        read_reg("sub2_r3", 4'd3, 16'hFFFE);

        // Overflow and carry out of ADD, plus shifts and logic ops
        issue("ld_r4", 4'd4, 4'hF, 4'hF, F_ADD, 1'b1, S_IMM, 1'b1);
        issue("shr", 4'd5, 4'd4, 4'd0, F_SHR, 1'b1, S_F, 1'b1);
        check_eq("shr_flags", {28'd0, flags}, 32'h4);
        issue("ld_r6", 4'd6, 4'h0, 4'h1, F_ADD, 1'b1, S_IMM, 1'b1);
        issue("add_ovf", 4'd7, 4'd5, 4'd6, F_ADD, 1'b0, S_F, 1'b1);
        check_eq("add_ovf_flags", {28'd0, flags}, 32'hA);
        read_reg("add_ovf_r7", 4'd7, 16'h8000);
        issue("add_carry", 4'd7, 4'd4, 4'd1, F_ADD, 1'b1, S_F, 1'b1);
        check_eq("add_carry_flags", {28'd0, flags}, 32'h5);
        read_reg("add_carry_r7", 4'd7, 16'h0000);
        issue("xor", 4'd8, 4'd4, 4'd3, F_XOR, 1'b0, S_F, 1'b1);
        check_eq("xor_flags", {28'd0, flags}, 32'h0);
        read_reg("xor_r8", 4'd8, 16'h0001);
        issue("and", 4'd8, 4'd4, 4'd1, F_AND, 1'b0, S_F, 1'b1);
        read_reg("and_r8", 4'd8, 16'h0005);
        issue("shl", 4'd8, 4'd5, 4'd0, F_SHL, 1'b1, S_F, 1'b1);
        check_eq("shl_flags", {28'd0, flags}, 32'h2);
        read_reg("shl_r8", 4'd8, 16'hFFFE);
        issue("or", 4'd8, 4'd3, 4'd6, F_OR, 1'b0, S_F, 1'b1);
        read_reg("or_r8", 4'd8, 16'hFFFF);

        // Back-to-back dependent issue
        @(posedge clk); #1;
        stalls = 0;
        issue("b2b_ld", 4'd1, 4'h0, 4'h7, F_ADD, 1'b1, S_IMM, 1'b1);
        issue("b2b_add", 4'd2, 4'd1, 4'd1, F_ADD, 1'b0, S_F, 1'b1);
        check_eq("b2b_stalls", stalls, EXP_B2B_STALLS);
        read_reg("b2b_r2", 4'd2, 16'h000E);

        // Memory load and PC capture
        issue("ld_r1b", 4'd1, 4'h2, 4'h0, F_ADD, 1'b1, S_IMM, 1'b1);
        MemIn = 16'hBEEF;
        issue("mem", 4'd9, 4'd1, 4'd0, F_ADD, 1'b1, S_MEM, 1'b1);
        check_eq("mem_memaddr", {16'd0, acc_memaddr}, 32'h0020);
        read_reg("mem_r9", 4'd9, 16'hBEEF);
        PC = 16'h1234;
        issue("pc", 4'd10, 4'd0, 4'd0, F_ADD, 1'b1, S_PC, 1'b1);
        read_reg("pc_r10", 4'd10, 16'h1234);

        // Reset while a write sits in writeback
        issue("rst_wb", 4'd4, 4'h3, 4'h3, F_ADD, 1'b1, S_IMM, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check_eq("rst_wb_valid2", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_flags2", {28'd0, flags}, 32'd0);
        read_reg("rst_r4", 4'd4, 16'h0000);
        read_reg("rst_r9", 4'd9, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_datapath_pipe.md
CPU_DATAPATH_PIPE -- requirements
Module: cpu_datapath_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data bus width in bits; legal range 8 to 32.
REQ-002 Parameter ADDR_W, default 4: register address width; register count is 2**ADDR_W.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1: synchronous active-high reset.
REQ-005 Ports in_valid (input, 1) and in_ready (output, 1): issue handshake; an instruction issues on a cycle where both are high.
REQ-006 Ports DA, AA and BA, input, ADDR_W each: destination, source S and source T register addresses.
REQ-007 Port FS, input, 3: function select.
REQ-008 Port MB, input, 1: T-operand select; 1 = zero-extended BA, 0 = register BA.
REQ-009 Port result_source, input, 2: result select; 0 = F, 1 = PC, 2 = MemIn, 3 = immediate.
REQ-010 Port RW, input, 1: register write enable.
REQ-011 Port MemIn, input, WIDTH: read data from asynchronous RAM.
REQ-012 Port PC, input, WIDTH: program counter value.
REQ-013 Port MemAddr, output, WIDTH: combinational forwarded S operand.
REQ-014 Port Dout, output, WIDTH: combinational forwarded value of register DA, for branch evaluation.
REQ-015 Port flags, output, 4: registered {V,C,N,Z}.
REQ-016 Port wb_valid, output, 1: high while the writeback stage holds an instruction.

Function
REQ-017 The datapath SHALL have two stages: the issue stage (register read, FU, result mux) and the writeback stage (register WB latched at issue, register-file write).
REQ-018 At issue, stage WB SHALL capture DA, RW, the result and the new flags; wb_valid SHALL be high the following cycle.
REQ-019 The register file SHALL write WB.result to WB.DA at the end of any cycle in which wb_valid and WB.RW are both high.
REQ-020 FS codes SHALL be: 0 ADD, 1 SUB (S-T), 2 AND, 3 OR, 4 XOR, 5 NOT S, 6 SHL1 S, 7 SHR1 S (logical); results are WIDTH bits with carry out going to C.
REQ-021 The immediate SHALL be {AA,BA} sign-extended from 2*ADDR_W bits to WIDTH.
REQ-022 flags SHALL update one cycle after an issue with result_source=0; other issues SHALL leave flags unchanged.
REQ-023 Flag rules: Z = (F==0); N = F[WIDTH-1]; C = carry for ADD, not-borrow for SUB, shifted-out bit for shifts, 0 otherwise; V = signed overflow for ADD/SUB, 0 otherwise.
REQ-024 A hazard SHALL exist when wb_valid and WB.RW are high and WB.DA equals AA, equals BA with MB=0, or equals DA for the Dout path.
REQ-025 Back-to-back issues SHALL be accepted with one-cycle issue-to-use latency when forwarding is enabled.
REQ-026 When in_ready is low, the source SHALL hold all instruction inputs stable; the block SHALL NOT sample them.
REQ-027 When in_valid is low, the block SHALL issue nothing and SHALL clear wb_valid the next cycle.

Reset
REQ-028 While reset is high, the block SHALL clear all registers to 0, clear wb_valid and flags to 0, and drive in_ready high the cycle after reset.
REQ-029 An instruction in WB when reset is asserted SHALL NOT be written.

Configuration
REQ-030 With DATAPATH_FWD_EN defined, hazards SHALL bypass WB.result into the S, T and Dout paths, and in_ready SHALL stay constantly 1 outside reset.
REQ-031 Without DATAPATH_FWD_EN, a hazard SHALL drive in_ready=0 for exactly one cycle, and the instruction SHALL then issue reading the written register file.

Structure
REQ-032 Package datapath_pkg SHALL hold the FS codes, the result_source codes and the flag bit indices.
REQ-033 Sub-module reg_file SHALL be parametrised by WIDTH and ADDR_W, with synchronous write, three asynchronous reads (A, B, D) and synchronous reset.

Verification
REQ-034 Scenario: reset, then issue DA=1, result_source=3, AA=4'hF, BA=4'h6, RW=1 -> R1=16'hFFF6 two cycles later, and flags stay 0.
REQ-035 Scenario: R1=5, R2=3, SUB DA=3 AA=1 BA=2 MB=0 -> R3=2, flags C=1 Z=0 N=0 V=0; then SUB DA=3 AA=2 BA=1 -> R3=16'hFFFE, N=1, C=0.
REQ-036 Scenario: ADD 16'h7FFF+1 -> result 16'h8000, V=1, N=1; ADD 16'hFFFF+1 -> result 0, Z=1, C=1.
REQ-037 Scenario: back-to-back R1<=imm 7 then ADD DA=2 AA=1 BA=1 -> with FWD_EN, R2=14 and in_ready never drops; without FWD_EN, exactly one in_ready=0 cycle, R2=14.
REQ-038 Scenario: assert reset on the cycle WB holds a write to R4 -> R4 remains 0, wb_valid=0.
REQ-039 Scenario: result_source=2 with AA=1 (R1=16'h0020), MemIn=16'hBEEF -> MemAddr=16'h0020 in the issue cycle, and the destination register receives 16'hBEEF.
